mitm_cmd_ctrl: RTL

Command controller for the UART man-in-the-middle. It consumes bytes decoded by the PC-side `uart_rx` and parses two-byte enable/disable commands and a one-byte status query. It maintains the forwarding-enable register that gates the board-1 and board-2 paths of `uart_mitm`, and sequences one reply byte per command through the PC-side `uart_tx` using its `en`/`rdy` handshake.

---
 rtl/mitm_pkg.sv | 25 ++
 rtl/mitm_cmd_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mitm_pkg.sv
// Shared opcodes, reply codes, controller state encoding and baud helper
// for the UART man-in-the-middle blocks.
package mitm_pkg;

  localparam logic [7:0] OP_EN   = 8'h65;
  localparam logic [7:0] OP_DIS  = 8'h64;
  localparam logic [7:0] OP_STAT = 8'h73;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG,
    ST_EXEC,
    ST_TX_REQ,
    ST_TX_WAIT_LO,
    ST_TX_WAIT_HI
  } ctrl_state_t;

  // Clock cycles per UART bit, truncated. This matches uart_tx/uart_rx.
  function automatic int CYC_COUNT(input int system_clock, input int baud_rate);
    return system_clock / baud_rate;
  endfunction

endpackage

// File: rtl/mitm_cmd_ctrl.sv
// PC-side command parser for the UART MITM. It owns the forwarding enables and
// sends one reply byte per command through the uart_tx en/rdy handshake.
module mitm_cmd_ctrl
  import mitm_pkg::*;
#(
  parameter int         SYSTEM_CLOCK  = 32000000,
  parameter int         BAUD_RATE     = 115200,
  parameter int         TIMEOUT_BYTES = 4,
  parameter logic [1:0] RESET_FWD     = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_rdy,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic [1:0] fwd_en,
  output logic       busy,
  output logic       err
);

  localparam int            LIMIT      = TIMEOUT_BYTES * 10 * CYC_COUNT(SYSTEM_CLOCK, BAUD_RATE);
  localparam int            CW         = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C    = CW'(LIMIT);
  localparam logic [3:0]    TX_LO_LAST = 4'd14;

  ctrl_state_t   r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_lo_cnt;
  logic          r_op_en;
  logic [7:0]    r_mask;
  logic [1:0]    r_fwd;
  logic [7:0]    r_tx_data;
  logic          r_err;

  logic          w_err;
  logic          w_load;
  logic [7:0]    w_reply;
  logic          w_fwd_upd;
  logic [1:0]    w_fwd_nxt;
  logic          w_mask_ok;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_next    = r_state;
    w_err     = 1'b0;
    w_load    = 1'b0;
    w_reply   = RSP_NAK;
    w_fwd_upd = 1'b0;
    w_mask_ok = (r_mask[7:2] == 6'd0);
    w_fwd_nxt = r_op_en ? (r_fwd | r_mask[1:0]) : (r_fwd & ~r_mask[1:0]);

    case (r_state)
      ST_IDLE: if (rx_valid) begin
        if (rx_data == OP_EN || rx_data == OP_DIS) begin
          w_next = ST_ARG;
        end else if (rx_data == OP_STAT) begin
          w_next  = ST_TX_REQ;
          w_load  = 1'b1;
          w_reply = {6'b0, r_fwd};
        end else begin
          w_next = ST_TX_REQ;
          w_load = 1'b1;
          w_err  = 1'b1;
        end
      end
      ST_ARG: begin
        if (rx_valid) begin
          w_next = ST_EXEC;
        end else if (r_cnt == LIMIT_C) begin
          w_next = ST_TX_REQ;
          w_load = 1'b1;
          w_err  = 1'b1;
        end
      end
      ST_EXEC: begin
        w_next = ST_TX_REQ;
        w_load = 1'b1;
        if (w_mask_ok) begin
          w_reply   = RSP_ACK;
          w_fwd_upd = 1'b1;
        end else begin
          w_err = 1'b1;
        end
      end
      ST_TX_REQ:     if (tx_rdy) w_next = ST_TX_WAIT_LO;
      ST_TX_WAIT_LO: begin
        // A transmitter that never drops rdy must not wedge the controller.
        if (!tx_rdy) w_next = ST_TX_WAIT_HI;
        else if (r_lo_cnt == TX_LO_LAST) w_next = ST_IDLE;
      end
      ST_TX_WAIT_HI: if (tx_rdy) w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase

    // The link is half-duplex, so a byte that arrives mid-command is dropped and flagged.
    if (rx_valid && (r_state inside {ST_EXEC, ST_TX_REQ, ST_TX_WAIT_LO, ST_TX_WAIT_HI}))
      w_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_lo_cnt  <= '0;
      r_op_en   <= 1'b0;
      r_mask    <= '0;
      r_fwd     <= RESET_FWD;
      r_tx_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err;
      if (w_load)    r_tx_data <= w_reply;
      if (w_fwd_upd) r_fwd     <= w_fwd_nxt;
      if (r_state == ST_IDLE && rx_valid) r_op_en <= (rx_data == OP_EN);
      if (r_state == ST_ARG && rx_valid)  r_mask  <= rx_data;

      if (r_state == ST_IDLE)                        r_cnt <= '0;
      else if (r_state == ST_ARG && r_cnt != LIMIT_C) r_cnt <= r_cnt + CW'(1);

      if (r_state != ST_TX_WAIT_LO) r_lo_cnt <= '0;
      else if (r_lo_cnt != 4'hF)    r_lo_cnt <= r_lo_cnt + 4'd1;
    end
  end

  // tx_en is combinational so that it can never be high while tx_rdy is low.
  assign tx_en   = rst && (r_state == ST_TX_REQ) && tx_rdy;
  assign tx_data = r_tx_data;
  assign fwd_en  = r_fwd;
  assign busy    = (r_state != ST_IDLE);
  assign err     = r_err;

endmodule
